instr_encoder: RTL and testbench

Encodes instruction fields into the 32-bit instruction word and writes it sequentially into instruction memory. Loads programs for the 16-bit Harvard core from a testbench or host over a valid/ready interface. Its word formats are exactly those the decode stage consumes: opcode in [31:26], field positions fixed per opcode. It also owns the instruction-memory write pointer, plus full/done status.

---
 rtl/isa_pkg.sv | 39 +++
 rtl/instr_encoder_if.sv | 17 +
 rtl/instr_pack.sv | 33 +++
 rtl/instr_encoder.sv | 85 ++++++++
 tb/tb_instr_encoder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: opcodes, field positions, word formats and encoder FSM states shared by encoder and decode.
// No ports; OP_MAX marks the highest legal opcode.
package isa_pkg;
   localparam logic [5:0] OP_MOVI = 6'd0;
   localparam logic [5:0] OP_MOV  = 6'd1;
   localparam logic [5:0] OP_LOAD = 6'd2;
   localparam logic [5:0] OP_STORE = 6'd3;
   localparam logic [5:0] OP_ADD  = 6'd4;
   localparam logic [5:0] OP_SUB  = 6'd5;
   localparam logic [5:0] OP_NEG  = 6'd6;
   localparam logic [5:0] OP_MUL  = 6'd7;
   localparam logic [5:0] OP_DIV  = 6'd8;
   localparam logic [5:0] OP_OR   = 6'd9;
   localparam logic [5:0] OP_XOR  = 6'd10;
   localparam logic [5:0] OP_NAND = 6'd11;
   localparam logic [5:0] OP_NOR  = 6'd12;
   localparam logic [5:0] OP_XNOR = 6'd13;
   localparam logic [5:0] OP_NOT  = 6'd14;
   localparam logic [5:0] OP_LLSH = 6'd15;
   localparam logic [5:0] OP_LRSH = 6'd16;
   localparam logic [5:0] OP_MAX  = 6'd16;
   localparam int OPC_LSB      = 26;
   localparam int RD2_LSB      = 21;
   localparam int RD1_LSB      = 16;
   localparam int IMM_LSB      = 0;
   localparam int RS2_LSB      = 0;
   localparam int MADDR_LD_LSB = 0;
   localparam int MADDR_ST_LSB = 18;
   localparam int RS2_R4_LSB   = 5;
   localparam int RS1_LSB      = 0;
   typedef enum logic [2:0] {FMT_IMM, FMT_RR, FMT_LD, FMT_ST, FMT_R4} fmt_t;
   typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_FULL} enc_state_t;
   function automatic fmt_t fmt_of(input logic [5:0] op);
      return op == OP_MOVI ? FMT_IMM :
             op == OP_MOV ? FMT_RR :
             op == OP_LOAD ? FMT_LD :
             op == OP_STORE ? FMT_ST : FMT_R4;
   endfunction
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle valid/ready channel into the encoder.
// Signals: in_valid, in_ready, in_last, op, rd2, rd1, rs2, rs1, imm, maddr.
// master = host driving bundles; slave = encoder.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_last;
   logic [5:0]  op;
   logic [4:0]  rd2;
   logic [4:0]  rd1;
   logic [4:0]  rs2;
   logic [4:0]  rs1;
   logic [15:0] imm;
   logic [7:0]  maddr;
   modport master (output in_valid, in_last, op, rd2, rd1, rs2, rs1, imm, maddr, input in_ready);
   modport slave (input in_valid, in_last, op, rd2, rd1, rs2, rs1, imm, maddr, output in_ready);
endinterface

// File: rtl/instr_pack.sv
// instr_pack: combinational map of opcode plus fields to {legal, 32-bit instruction word}.
// Ports: op/rd2/rd1/rs2/rs1/imm/maddr in; legal, word out. Unlisted word bits are 0.
module instr_pack
   import isa_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [4:0]  rd2,
   input  logic [4:0]  rd1,
   input  logic [4:0]  rs2,
   input  logic [4:0]  rs1,
   input  logic [15:0] imm,
   input  logic [7:0]  maddr,
   output logic        legal,
   output logic [31:0] word
);
   always_comb begin
      word = '0;
      word[OPC_LSB +: 6] = op;
      case (fmt_of(op))
         FMT_IMM: begin word[RD2_LSB +: 5] = rd2; word[IMM_LSB +: 16] = imm; end
         FMT_RR:  begin word[RD2_LSB +: 5] = rd2; word[RS2_LSB +: 5] = rs2; end
         FMT_LD:  begin word[RD2_LSB +: 5] = rd2; word[MADDR_LD_LSB +: 8] = maddr; end
         FMT_ST:  begin word[MADDR_ST_LSB +: 8] = maddr; word[RS2_LSB +: 5] = rs2; end
         default: begin
            word[RD2_LSB +: 5] = rd2;
            word[RD1_LSB +: 5] = rd1;
            word[RS2_R4_LSB +: 5] = rs2;
            word[RS1_LSB +: 5] = rs1;
         end
      endcase
      legal = op <= OP_MAX;
   end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes field bundles and writes them sequentially into instruction memory.
// Ports: clk, rst (async active-high), start, bus (instr_encoder_if.slave),
//   imem_we/imem_addr/imem_wdata write port, wr_count, done, full, err_illegal, checksum.
// Optional macro ENC_CHECKSUM_EN: rotate-left-1/XOR checksum of written words; otherwise checksum = 0.
module instr_encoder
   import isa_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   instr_encoder_if.slave    bus,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   wr_count,
   output logic              done,
   output logic              full,
   output logic              err_illegal,
   output logic [31:0]       checksum
);
   enc_state_t state, next;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0] cnt;
   logic [31:0] word_q, pword;
   logic last_q, legal, hs;
   instr_pack u_pack (
      .op(bus.op), .rd2(bus.rd2), .rd1(bus.rd1), .rs2(bus.rs2), .rs1(bus.rs1),
      .imm(bus.imm), .maddr(bus.maddr), .legal(legal), .word(pword)
   );
   // start wins over a coincident bundle
   assign hs = state == S_ACCEPT && bus.in_valid && !start;
   always_comb begin
      next = state;
      case (state)
         S_ACCEPT: next = hs && legal ? S_WRITE : S_ACCEPT;
         S_WRITE:  next = start ? S_ACCEPT : last_q ? S_DONE : &ptr ? S_FULL : S_ACCEPT;
         default:  next = start ? S_ACCEPT : state;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         ptr <= '0;
         cnt <= '0;
         word_q <= '0;
         last_q <= 1'b0;
         err_illegal <= 1'b0;
      end else begin
         state <= next;
         err_illegal <= hs && !legal;
         if (hs && legal) begin
            word_q <= pword;
            last_q <= bus.in_last;
         end
         // pointer saturates at the top address; only start brings it back to 0
         if (state == S_WRITE) begin
            ptr <= start ? '0 : &ptr ? ptr : ptr + 1'b1;
            cnt <= start ? '0 : cnt + 1'b1;
         end else if (start) begin
            ptr <= '0;
            cnt <= '0;
         end
      end
   end
   assign bus.in_ready = state == S_ACCEPT;
   assign imem_we = state == S_WRITE;
   assign imem_addr = ptr;
   assign imem_wdata = word_q;
   assign wr_count = cnt;
   assign done = state == S_DONE;
   assign full = state == S_FULL;
`ifdef ENC_CHECKSUM_EN
   logic [31:0] cs;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cs <= '0;
      else if (start) cs <= '0;
      else if (state == S_WRITE) cs <= {cs[30:0], cs[31]} ^ word_q;
   end
   assign checksum = cs;
`else
   assign checksum = '0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized self-checking bench for instr_encoder against an arithmetic reference model.
module tb_instr_encoder;
   localparam int AW = 8;
   logic clk = 0, rst = 1, start = 0;
   logic imem_we, done, full, err_illegal;
   logic [AW-1:0] imem_addr;
   logic [31:0] imem_wdata, checksum;
   logic [AW:0] wr_count;
   int checks = 0, failures = 0;
   int exp_ptr = 0, exp_cnt = 0;
   logic [31:0] cs_m = 0;
   instr_encoder_if bus();
   instr_encoder #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus.slave),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .wr_count(wr_count), .done(done), .full(full), .err_illegal(err_illegal),
      .checksum(checksum)
   );
   always #5 clk = ~clk;

   function automatic logic [31:0] enc_ref(int o, int a, int b, int c, int d, int im, int ma);
      int unsigned r;
      r = o << 26;
      if (o == 0) r = r | (a << 21) | im;
      else if (o == 1) r = r | (a << 21) | c;
      else if (o == 2) r = r | (a << 21) | ma;
      else if (o == 3) r = r | (ma << 18) | c;
      else r = r | (a << 21) | (b << 16) | (c << 5) | d;
      return r;
   endfunction

   function automatic logic [31:0] exp_cs();
`ifdef ENC_CHECKSUM_EN
      return cs_m;
`else
      return 32'd0;
`endif
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      step();
      start = 1;
      step();
      start = 0;
      exp_ptr = 0; exp_cnt = 0; cs_m = 0;
   endtask

   // drive one bundle and return in the cycle right after the handshake edge
   task automatic put(int o, int a, int b, int c, int d, int im, int ma, bit last);
      int n = 0;
      bus.op = 6'(o); bus.rd2 = 5'(a); bus.rd1 = 5'(b); bus.rs2 = 5'(c); bus.rs1 = 5'(d);
      bus.imm = 16'(im); bus.maddr = 8'(ma); bus.in_last = last; bus.in_valid = 1;
      while (bus.in_ready !== 1'b1 && n < 20) begin step(); n++; end
      if (n == 20) begin
         checks++; failures++;
         $display("FAIL handshake_timeout in_ready=%b required=1", bus.in_ready);
      end
      step();
      bus.in_valid = 0; bus.in_last = 0;
   endtask

   task automatic model_write(logic [31:0] w);
      cs_m = ((cs_m << 1) | (cs_m >> 31)) ^ w;
      exp_ptr++; exp_cnt++;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) step();
      checks++;
      if ({imem_we, imem_addr, imem_wdata, wr_count, done, full, err_illegal, checksum, bus.in_ready} !== '0) begin
         failures++;
         $display("FAIL reset_values we=%b addr=%h wdata=%h cnt=%0d done=%b full=%b err=%b cs=%h rdy=%b required all 0",
                  imem_we, imem_addr, imem_wdata, wr_count, done, full, err_illegal, checksum, bus.in_ready);
      end
      rst = 0;
      step();
   endtask

   task automatic test_directed();
      int t[4][7] = '{'{0,3,0,0,0,'h1234,0}, '{4,1,2,3,4,0,0}, '{3,0,0,7,0,0,'hA5}, '{2,5,0,0,0,0,'h3C}};
      logic [31:0] req[4] = '{32'h00601234, 32'h10220064, 32'h0E940007, 32'h08A0003C};
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         put(t[i][0], t[i][1], t[i][2], t[i][3], t[i][4], t[i][5], t[i][6], 0);
         checks++;
         if (imem_we !== 1'b1 || imem_addr !== 8'(exp_ptr) || imem_wdata !== req[i]) begin
            failures++;
            $display("FAIL directed_write[%0d] we=%b addr=%h wdata=%h required we=1 addr=%h wdata=%h",
                     i, imem_we, imem_addr, imem_wdata, 8'(exp_ptr), req[i]);
         end
         model_write(req[i]);
         step();
         checks++;
         if (imem_we !== 1'b0 || wr_count !== 9'(exp_cnt)) begin
            failures++;
            $display("FAIL directed_count[%0d] we=%b cnt=%0d required we=0 cnt=%0d", i, imem_we, wr_count, exp_cnt);
         end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] w;
      bus.op = 6'h3F; bus.in_valid = 1;
      step();
      bus.in_valid = 0;
      checks++;
      if (imem_we !== 1'b0 || err_illegal !== 1'b1 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL illegal_reject we=%b err=%b rdy=%b required we=0 err=1 rdy=1", imem_we, err_illegal, bus.in_ready);
      end
      step();
      checks++;
      if (err_illegal !== 1'b0 || imem_addr !== 8'(exp_ptr) || wr_count !== 9'(exp_cnt)) begin
         failures++;
         $display("FAIL illegal_after err=%b addr=%h cnt=%0d required err=0 addr=%h cnt=%0d",
                  err_illegal, imem_addr, wr_count, 8'(exp_ptr), exp_cnt);
      end
      w = enc_ref(1, 9, 0, 17, 0, 0, 0);
      put(1, 9, 0, 17, 0, 0, 0, 0);
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== 8'(exp_ptr) || imem_wdata !== w) begin
         failures++;
         $display("FAIL illegal_next_write we=%b addr=%h wdata=%h required we=1 addr=%h wdata=%h",
                  imem_we, imem_addr, imem_wdata, 8'(exp_ptr), w);
      end
      model_write(w);
      step();
   endtask

   task automatic test_start_wins();
      bus.op = 6'd5; bus.in_valid = 1; start = 1;
      step();
      bus.in_valid = 0; start = 0;
      exp_ptr = 0; exp_cnt = 0; cs_m = 0;
      checks++;
      if (imem_we !== 1'b0 || bus.in_ready !== 1'b1 || imem_addr !== 8'd0 || wr_count !== 9'd0) begin
         failures++;
         $display("FAIL start_wins we=%b rdy=%b addr=%h cnt=%0d required we=0 rdy=1 addr=0 cnt=0",
                  imem_we, bus.in_ready, imem_addr, wr_count);
      end
   endtask

   task automatic test_random_program(int n);
      int o, a, b, c, d, im, ma;
      logic [31:0] w;
      pulse_start();
      for (int i = 0; i < n; i++) begin
         o = $urandom_range(0, 16); a = $urandom_range(0, 31); b = $urandom_range(0, 31);
         c = $urandom_range(0, 31); d = $urandom_range(0, 31);
         im = $urandom_range(0, 65535); ma = $urandom_range(0, 255);
         w = enc_ref(o, a, b, c, d, im, ma);
         put(o, a, b, c, d, im, ma, i == n - 1);
         checks++;
         if (imem_we !== 1'b1 || imem_addr !== 8'(exp_ptr) || imem_wdata !== w) begin
            failures++;
            $display("FAIL random_write[%0d] op=%0d we=%b addr=%h wdata=%h required we=1 addr=%h wdata=%h",
                     i, o, imem_we, imem_addr, imem_wdata, 8'(exp_ptr), w);
         end
         model_write(w);
         step();
      end
      checks++;
      if (done !== 1'b1 || bus.in_ready !== 1'b0 || full !== 1'b0 || wr_count !== 9'(exp_cnt) || checksum !== exp_cs()) begin
         failures++;
         $display("FAIL program_done done=%b rdy=%b full=%b cnt=%0d cs=%h required done=1 rdy=0 full=0 cnt=%0d cs=%h",
                  done, bus.in_ready, full, wr_count, checksum, exp_cnt, exp_cs());
      end
   endtask

   task automatic test_full();
      int o, a, b, c, d, im, ma, bad = 0;
      logic [31:0] w;
      pulse_start();
      for (int i = 0; i < 256; i++) begin
         o = $urandom_range(0, 16); a = $urandom_range(0, 31); b = $urandom_range(0, 31);
         c = $urandom_range(0, 31); d = $urandom_range(0, 31);
         im = $urandom_range(0, 65535); ma = $urandom_range(0, 255);
         w = enc_ref(o, a, b, c, d, im, ma);
         put(o, a, b, c, d, im, ma, 0);
         checks++;
         if (imem_we !== 1'b1 || imem_addr !== 8'(exp_ptr) || imem_wdata !== w || (i < 255 && full !== 1'b0)) begin
            failures++;
            $display("FAIL fill_write[%0d] we=%b addr=%h wdata=%h full=%b required we=1 addr=%h wdata=%h full=0",
                     i, imem_we, imem_addr, imem_wdata, full, 8'(exp_ptr), w);
         end
         model_write(w);
         step();
      end
      checks++;
      if (full !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b0 || wr_count !== 9'd256) begin
         failures++;
         $display("FAIL full_state full=%b done=%b rdy=%b cnt=%0d required full=1 done=0 rdy=0 cnt=256",
                  full, done, bus.in_ready, wr_count);
      end
      pulse_start();
      checks++;
      if (full !== 1'b0 || bus.in_ready !== 1'b1 || wr_count !== 9'd0 || imem_addr !== 8'd0) begin
         failures++;
         $display("FAIL full_restart full=%b rdy=%b cnt=%0d addr=%h required full=0 rdy=1 cnt=0 addr=0",
                  full, bus.in_ready, wr_count, imem_addr);
      end
   endtask

   task automatic test_reset_mid_write();
      put(4, 1, 2, 3, 4, 0, 0, 0);
      checks++;
      if (imem_we !== 1'b1) begin
         failures++;
         $display("FAIL mid_write_setup we=%b required 1", imem_we);
      end
      rst = 1;
      #1;
      checks++;
      if ({imem_we, imem_addr, imem_wdata, wr_count, done, full, err_illegal, checksum, bus.in_ready} !== '0) begin
         failures++;
         $display("FAIL reset_mid_write we=%b addr=%h wdata=%h cnt=%0d done=%b full=%b err=%b cs=%h rdy=%b required all 0",
                  imem_we, imem_addr, imem_wdata, wr_count, done, full, err_illegal, checksum, bus.in_ready);
      end
      step();
      rst = 0;
      step();
   endtask

   initial begin
      bus.in_valid = 0; bus.in_last = 0; bus.op = 0; bus.rd2 = 0; bus.rd1 = 0;
      bus.rs2 = 0; bus.rs1 = 0; bus.imm = 0; bus.maddr = 0;
      test_reset();
      test_directed();
      test_illegal();
      test_start_wins();
      test_random_program(3);
      test_random_program(20);
      test_full();
      pulse_start();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
